inv_shift_rows_dr_stage: RTL and testbench

//  Registered dual-rail (T/F) AES InvShiftRows stage for the decryption datapath; exact inverse of the forward dual-rail ShiftRows.

---
 rtl/aes_dr_pkg.sv | 30 +++
 rtl/inv_shift_rows_dr_perm.sv | 18 +
 rtl/inv_shift_rows_dr_stage.sv | 141 ++++++++++++++
 tb/tb_inv_shift_rows_dr_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dr_pkg.sv
// ---------------------------------------------------------------------------
// aes_dr_pkg
// Shared definitions for the dual-rail (T/F) AES decryption datapath.
//   N / BYTE / WORD : state, byte and column-word widths
//   INV_SR_SRC      : InvShiftRows source byte index for each output byte
//                     (byte k = bits [8k+7:8k])
//   inv_sr_state_e  : stage FSM states
//   dr_rail_err     : flags any bit position whose rails are not complementary
// ---------------------------------------------------------------------------
package aes_dr_pkg;

  localparam int N    = 128;
  localparam int BYTE = 8;
  localparam int WORD = 32;

  // Output byte k takes input byte INV_SR_SRC[k].
  localparam int INV_SR_SRC [16] = '{12, 9, 6, 3, 0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15};

  typedef enum logic [1:0] {
    SPACER = 2'd0,
    IDLE   = 2'd1,
    HOLD   = 2'd2
  } inv_sr_state_e;

  // A valid dual-rail bit is 01 or 10; 00 or 11 on any position is an error.
  function automatic logic dr_rail_err(input logic [N-1:0] t, input logic [N-1:0] f);
    return |(~(t ^ f));
  endfunction

endpackage

// File: rtl/inv_shift_rows_dr_perm.sv
// ---------------------------------------------------------------------------
// inv_shift_rows_dr_perm
// Combinational single-rail InvShiftRows byte permutation.
//   i_data [N-1:0] : one rail of the input state
//   o_data [N-1:0] : same rail, bytes rearranged by INV_SR_SRC
// ---------------------------------------------------------------------------
module inv_shift_rows_dr_perm
  import aes_dr_pkg::*;
(
  input  logic [N-1:0] i_data,
  output logic [N-1:0] o_data
);

  for (genvar k = 0; k < 16; k++) begin : g_byte
    assign o_data[k*BYTE +: BYTE] = i_data[INV_SR_SRC[k]*BYTE +: BYTE];
  end

endmodule

// File: rtl/inv_shift_rows_dr_stage.sv
// ---------------------------------------------------------------------------
// inv_shift_rows_dr_stage
// Registered dual-rail AES InvShiftRows stage with valid/ready handshake.
// After every token leaves (or is dropped) the output rails sit at all-zero
// spacer for SPACER_CYC cycles so each token causes the same rail switching.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid / in_ready    : upstream handshake (in_ready registered)
//   Text_In_T / Text_In_F  : input true / false rails
//   out_valid / out_ready  : downstream handshake
//   Out_Text_T / Out_Text_F: registered inverse-shifted rails
//   fault                  : sticky rail-integrity alarm
// Optional feature macro: INV_SR_FAULT_DETECT_EN
//   defined   -> non-complementary rails at accept set fault, token dropped
//   undefined -> no check, fault stays 0, every token forwarded
// ---------------------------------------------------------------------------
module inv_shift_rows_dr_stage
  import aes_dr_pkg::*;
#(
  parameter int SPACER_CYC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] Text_In_T,
  input  logic [N-1:0] Text_In_F,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Out_Text_T,
  output logic [N-1:0] Out_Text_F,
  output logic         fault
);

  localparam logic [3:0] CNT_RELOAD = 4'(SPACER_CYC - 1);

  inv_sr_state_e r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          r_in_ready, w_in_ready_nxt;
  logic          r_out_valid, w_out_valid_nxt;
  logic [N-1:0]  r_out_t, w_out_t_nxt;
  logic [N-1:0]  r_out_f, w_out_f_nxt;
  logic          r_fault, w_fault_nxt;
  logic [N-1:0]  w_perm_t, w_perm_f;
  logic          w_rail_err;

  inv_shift_rows_dr_perm u_perm_t (.i_data(Text_In_T), .o_data(w_perm_t));
  inv_shift_rows_dr_perm u_perm_f (.i_data(Text_In_F), .o_data(w_perm_f));

`ifdef INV_SR_FAULT_DETECT_EN
  assign w_rail_err = dr_rail_err(Text_In_T, Text_In_F);
`else
  assign w_rail_err = 1'b0;
`endif

  // Next-state, spacer counter and next output register values.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = r_out_valid;
    w_out_t_nxt     = r_out_t;
    w_out_f_nxt     = r_out_f;
    w_fault_nxt     = r_fault;
    case (r_state)
      SPACER: begin
        w_out_valid_nxt = 1'b0;
        w_out_t_nxt     = '0;
        w_out_f_nxt     = '0;
        if (r_cnt == 4'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      IDLE: begin
        if (in_valid) begin
          if (w_rail_err) begin
            // Faulty token never reaches the output register.
            w_fault_nxt = 1'b1;
            w_state_nxt = SPACER;
            w_cnt_nxt   = CNT_RELOAD;
          end else begin
            w_out_t_nxt     = w_perm_t;
            w_out_f_nxt     = w_perm_f;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = HOLD;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_out_t_nxt     = '0;
          w_out_f_nxt     = '0;
          w_state_nxt     = SPACER;
          w_cnt_nxt       = CNT_RELOAD;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_out_t_nxt     = '0;
        w_out_f_nxt     = '0;
        w_state_nxt     = SPACER;
        w_cnt_nxt       = CNT_RELOAD;
      end
    endcase
    // in_ready is the registered image of the state being IDLE.
    w_in_ready_nxt = (w_state_nxt == IDLE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SPACER;
      r_cnt       <= CNT_RELOAD;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_t     <= '0;
      r_out_f     <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_t     <= w_out_t_nxt;
      r_out_f     <= w_out_f_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign Out_Text_T = r_out_t;
  assign Out_Text_F = r_out_f;
  assign fault      = r_fault;

endmodule

// File: tb/tb_inv_shift_rows_dr_stage.sv
// ---------------------------------------------------------------------------
// tb_inv_shift_rows_dr_stage
// Drives two stage instances (SPACER_CYC = 1 and 3) and compares them against
// an AES row/column model of ShiftRows / InvShiftRows.
// Honours INV_SR_FAULT_DETECT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_inv_shift_rows_dr_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid_a  [2];
  logic         in_ready_a  [2];
  logic         out_valid_a [2];
  logic         out_ready_a [2];
  logic         fault_a     [2];
  logic [127:0] tin_t [2];
  logic [127:0] tin_f [2];
  logic [127:0] out_t [2];
  logic [127:0] out_f [2];

  int n_assert = 0;
  int n_fail   = 0;
  int S_OF [2] = '{1, 3};
  bit exp_fault [2];

  always #5 clk = ~clk;

  inv_shift_rows_dr_stage #(.SPACER_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .Text_In_T(tin_t[0]), .Text_In_F(tin_f[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
    .Out_Text_T(out_t[0]), .Out_Text_F(out_f[0]),
    .fault(fault_a[0])
  );

  inv_shift_rows_dr_stage #(.SPACER_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .Text_In_T(tin_t[1]), .Text_In_F(tin_f[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
    .Out_Text_T(out_t[1]), .Out_Text_F(out_f[1]),
    .fault(fault_a[1])
  );

  // AES state: byte b (b = 15 - k) sits at row b%4, column b/4.
  // Forward: out[r][c] = in[r][(c+r)%4]; inverse: out[r][c] = in[r][(c-r)%4].
  function automatic logic [127:0] sr_ref(input logic [127:0] s, input bit inv);
    logic [7:0]   a [16];
    logic [127:0] o;
    int           sc;
    o = '0;
    for (int b = 0; b < 16; b++) a[b] = s[(15-b)*8 +: 8];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[(15-(r+4*c))*8 +: 8] = a[r + 4*sc];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_rails(input int i, input string tag);
    chk({tag, "_ov"}, 128'(out_valid_a[i]), 128'd0);
    chk({tag, "_t"}, out_t[i], 128'd0);
    chk({tag, "_f"}, out_f[i], 128'd0);
  endtask

  // One token through instance i: wait for ready, accept, optional
  // backpressure, handshake, then spacer and return to ready.
  task automatic xfer(input int i, input logic [127:0] t, input logic [127:0] f,
                      input logic [127:0] et, input logic [127:0] ef,
                      input bit drop, input int hold, input string tag);
    int n = 0;
    while (in_ready_a[i] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rdy_wait"}, 128'(in_ready_a[i]), 128'd1);
    out_ready_a[i] = (hold == 0);
    in_valid_a[i]  = 1'b1;
    tin_t[i] = t;
    tin_f[i] = f;
    tick();
    // Upstream keeps presenting junk; it must be ignored outside IDLE.
    tin_t[i] = rnd128();
    tin_f[i] = rnd128();
    if (drop) exp_fault[i] = 1'b1;
    chk({tag, "_fault"}, 128'(fault_a[i]), 128'(exp_fault[i]));
    chk({tag, "_ir_busy"}, 128'(in_ready_a[i]), 128'd0);
    if (drop) begin
      chk_idle_rails(i, {tag, "_drop"});
    end else begin
      chk({tag, "_ov"}, 128'(out_valid_a[i]), 128'd1);
      chk({tag, "_t"}, out_t[i], et);
      chk({tag, "_f"}, out_f[i], ef);
      for (int h = 0; h < hold; h++) begin
        tick();
        chk({tag, "_hold_ov"}, 128'(out_valid_a[i]), 128'd1);
        chk({tag, "_hold_t"}, out_t[i], et);
        chk({tag, "_hold_f"}, out_f[i], ef);
        chk({tag, "_hold_ir"}, 128'(in_ready_a[i]), 128'd0);
      end
      out_ready_a[i] = 1'b1;
      in_valid_a[i]  = 1'b0;
      tick();
    end
    in_valid_a[i] = 1'b0;
    for (int j = 0; j < S_OF[i]; j++) begin
      chk_idle_rails(i, {tag, "_spc"});
      chk({tag, "_spc_ir"}, 128'(in_ready_a[i]), 128'd0);
      tick();
    end
    chk({tag, "_ir_back"}, 128'(in_ready_a[i]), 128'd1);
  endtask

  initial begin
    logic [127:0] x, fw, t, f;
    logic [127:0] map_t, map_e;
    bit           drop_fault;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_a[i]  = 1'b0;
      out_ready_a[i] = 1'b0;
      tin_t[i]       = '0;
      tin_f[i]       = '0;
      exp_fault[i]   = 1'b0;
    end
`ifdef INV_SR_FAULT_DETECT_EN
    drop_fault = 1'b1;
`else
    drop_fault = 1'b0;
`endif

    // Reset values, then in_ready rises after SPACER_CYC cycles.
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk_idle_rails(i, "rst");
      chk("rst_ir", 128'(in_ready_a[i]), 128'd0);
      chk("rst_fault", 128'(fault_a[i]), 128'd0);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      for (int i = 0; i < 2; i++)
        chk("rise_ir", 128'(in_ready_a[i]), 128'(c >= S_OF[i]));
    end

    // Fixed byte map.
    map_t = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    map_e = 128'h0F02_0508_0B0E_0104_070A_0D00_0306_090C;
    for (int i = 0; i < 2; i++)
      xfer(i, map_t, ~map_t, map_e, ~map_e, 1'b0, 0, "map");

    // Round trip: forward ShiftRows then this stage restores the state.
    for (int v = 0; v < 1000; v++) begin
      x  = rnd128();
      fw = sr_ref(x, 1'b0);
      xfer(0, fw, ~fw, x, ~x, 1'b0, 0, "rtrip");
    end
    for (int v = 0; v < 20; v++) begin
      x  = rnd128();
      fw = sr_ref(x, 1'b0);
      xfer(1, fw, ~fw, x, ~x, 1'b0, int'($urandom_range(0, 2)), "rtrip3");
    end

    // Backpressure for 5 cycles on both spacer lengths.
    for (int i = 0; i < 2; i++) begin
      t = rnd128();
      xfer(i, t, ~t, sr_ref(t, 1'b1), ~sr_ref(t, 1'b1), 1'b0, 5, "bp");
    end

    // Rail fault on bit 7 (T=F=1), then a clean token with fault sticky.
    for (int i = 0; i < 2; i++) begin
      t = rnd128();
      f = ~t;
      t[7] = 1'b1;
      f[7] = 1'b1;
      xfer(i, t, f, sr_ref(t, 1'b1), sr_ref(f, 1'b1), drop_fault, 0, "flt");
      t = rnd128();
      xfer(i, t, ~t, sr_ref(t, 1'b1), ~sr_ref(t, 1'b1), 1'b0, 1, "post_flt");
    end

    // Reset in the middle of HOLD clears outputs without a clock edge.
    t = rnd128();
    x = sr_ref(t, 1'b1);
    xfer(0, t, ~t, x, ~x, 1'b0, 0, "pre_rst");
    out_ready_a[0] = 1'b0;
    in_valid_a[0]  = 1'b1;
    tin_t[0] = t;
    tin_f[0] = ~t;
    tick();
    in_valid_a[0] = 1'b0;
    chk("mid_ov", 128'(out_valid_a[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_rails(0, "async_rst");
    chk("async_rst_ir", 128'(in_ready_a[0]), 128'd0);
    for (int i = 0; i < 2; i++) begin
      exp_fault[i] = 1'b0;
      chk("async_rst_fault", 128'(fault_a[i]), 128'd0);
    end
    tick();
    rst_n = 1'b1;
    t = rnd128();
    xfer(0, t, ~t, sr_ref(t, 1'b1), ~sr_ref(t, 1'b1), 1'b0, 2, "after_rst");
    t = rnd128();
    xfer(1, t, ~t, sr_ref(t, 1'b1), ~sr_ref(t, 1'b1), 1'b0, 0, "after_rst3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
